// File: rtl/gpu_sched_pkg.sv
// gpu_sched_pkg: shared core_state codes, fetcher FETCHED code and per-warp status type
package gpu_sched_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_EXECUTE = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;
  localparam logic [2:0] FETCHED   = 3'b010;
  typedef enum logic [1:0] {READY, PARKED, FINISHED} warp_status_t;
endpackage

// File: rtl/rr_next_eligible.sv
// rr_next_eligible: first set bit of eligible strictly after base (wrapping, base excluded); ports eligible,base in / found,idx out
module rr_next_eligible #(
  parameter int N  = 2,
  parameter int WB = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [WB-1:0] base,
  output logic          found,
  output logic [WB-1:0] idx
);
  logic [WB-1:0] c;
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = N - 1; k > 0; k--) begin
      c = WB'((int'(base) + k) % N);
      if (eligible[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/warp_scheduler.sv
// warp_scheduler: multi-warp FETCH..UPDATE sequencer with stall-driven round-robin switching; ports clk,reset,start,decoded_ret,fetcher_done,lsu_busy,next_pc in / core_state,active_warp,current_pc,warp_switch,warp_done,done,divergence_error out
module warp_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WARPS        = 2,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS          = 8,
  parameter int WARP_BITS        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       decoded_ret,
  input  logic                                       fetcher_done,
  input  logic [NUM_WARPS-1:0]                       lsu_busy,
  input  logic [THREADS_PER_WARP-1:0][PC_BITS-1:0]   next_pc,
  output logic [2:0]                                 core_state,
  output logic [WARP_BITS-1:0]                       active_warp,
  output logic [PC_BITS-1:0]                         current_pc,
  output logic                                       warp_switch,
  output logic [NUM_WARPS-1:0]                       warp_done,
  output logic                                       done,
  output logic                                       divergence_error
);
  logic [2:0]           state_q, state_d;
  logic [WARP_BITS-1:0] warp_q, warp_d;
  logic [PC_BITS-1:0]   cur_pc_q, cur_pc_d;
  logic                 switch_q, switch_d;
  logic [NUM_WARPS-1:0] wdone_q, wdone_d;
  logic                 done_q, done_d;
  logic                 div_q, div_d;
  logic [PC_BITS-1:0]   pc_q [NUM_WARPS];
  logic [PC_BITS-1:0]   pc_d [NUM_WARPS];
  warp_status_t         status_q [NUM_WARPS];
  warp_status_t         status_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] eligible;
  logic                 found, act_fin, diverged;
  logic [WARP_BITS-1:0] nxt;

  rr_next_eligible #(.N(NUM_WARPS), .WB(WARP_BITS)) u_rr (
    .eligible(eligible),
    .base    (warp_q),
    .found   (found),
    .idx     (nxt)
  );

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++)
      eligible[w] = status_q[w] == READY || (status_q[w] == PARKED && !lsu_busy[w]);
    diverged = 1'b0;
    for (int i = 1; i < THREADS_PER_WARP; i++)
      diverged = diverged | (next_pc[i] != next_pc[0]);
    act_fin = status_q[warp_q] == FINISHED;
  end

  always_comb begin
    state_d = state_q;
    warp_d = warp_q;
    cur_pc_d = cur_pc_q;
    switch_d = 1'b0;
    wdone_d = wdone_q;
    done_d = done_q;
    div_d = div_q;
    pc_d = pc_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        warp_d = '0;
        cur_pc_d = '0;
        wdone_d = '0;
        done_d = 1'b0;
        div_d = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
          pc_d[w] = '0;
          status_d[w] = READY;
        end
      end
      S_FETCH:   state_d = fetcher_done ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: if (!act_fin && !lsu_busy[warp_q]) begin
        state_d = S_EXECUTE;
      end else begin
        if (!act_fin) status_d[warp_q] = PARKED;
        if (found) begin
          warp_d = nxt;
          cur_pc_d = pc_q[nxt];
          switch_d = 1'b1;
          state_d = status_q[nxt] == PARKED ? S_EXECUTE : S_FETCH;
        end
      end
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: if (decoded_ret) begin
        wdone_d[warp_q] = 1'b1;
        status_d[warp_q] = FINISHED;
        done_d = &wdone_d;
        state_d = &wdone_d ? S_DONE : S_WAIT;
      end else begin
        pc_d[warp_q] = next_pc[0];
        cur_pc_d = next_pc[0];
        status_d[warp_q] = READY;
        div_d = div_q | diverged;
        state_d = S_FETCH;
      end
      S_DONE: state_d = start ? S_DONE : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      warp_q <= '0;
      cur_pc_q <= '0;
      switch_q <= 1'b0;
      wdone_q <= '0;
      done_q <= 1'b0;
      div_q <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= '0;
        status_q[w] <= READY;
      end
    end else begin
      state_q <= state_d;
      warp_q <= warp_d;
      cur_pc_q <= cur_pc_d;
      switch_q <= switch_d;
      wdone_q <= wdone_d;
      done_q <= done_d;
      div_q <= div_d;
      pc_q <= pc_d;
      status_q <= status_d;
    end
  end

  assign core_state = state_q;
  assign active_warp = warp_q;
  assign current_pc = cur_pc_q;
  assign warp_switch = switch_q;
  assign warp_done = wdone_q;
  assign done = done_q;
  assign divergence_error = div_q;
endmodule
